instr_encoder: RTL

Streaming AVR (ATtiny20 subset) instruction encoder. Packs decoded operation fields (type, Rd, Rr, immediate, bit) into the exact 16-bit instruction word the core's decoder expects. Words go out through a valid/ready stream with a write-address counter. It sits between the test/boot program generator and instruction memory, so programs are produced in the same field format the decode stage emits.

---
 rtl/instr_encoder_pkg.sv | 30 +++
 rtl/instr_encoder_if.sv | 14 +
 rtl/instr_encoder_pack.sv | 49 ++++
 rtl/instr_encoder.sv | 54 +++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: opcode type indices/one-hot TYPE_* codes, OPCODE_COUNT, encoding prefixes and field positions
package instr_encoder_pkg;
  typedef enum int unsigned {
    I_ADD, I_ADC, I_SUB, I_CP, I_AND, I_EOR, I_OR, I_MOV, I_NEG, I_NOP, I_LD_Y,
    I_LDI, I_LDS, I_STS, I_RJMP, I_BREQ, I_BRVC, I_BRBS, I_IN, I_OUT, I_UNKNOWN
  } op_idx_e;
  localparam int OPCODE_COUNT = 21;
  typedef logic [OPCODE_COUNT-1:0] op_type_t;
  localparam op_type_t TYPE_ADD = op_type_t'(1) << I_ADD, TYPE_ADC = op_type_t'(1) << I_ADC;
  localparam op_type_t TYPE_SUB = op_type_t'(1) << I_SUB, TYPE_CP = op_type_t'(1) << I_CP;
  localparam op_type_t TYPE_AND = op_type_t'(1) << I_AND, TYPE_EOR = op_type_t'(1) << I_EOR;
  localparam op_type_t TYPE_OR = op_type_t'(1) << I_OR, TYPE_MOV = op_type_t'(1) << I_MOV;
  localparam op_type_t TYPE_NEG = op_type_t'(1) << I_NEG, TYPE_NOP = op_type_t'(1) << I_NOP;
  localparam op_type_t TYPE_LD_Y = op_type_t'(1) << I_LD_Y, TYPE_LDI = op_type_t'(1) << I_LDI;
  localparam op_type_t TYPE_LDS = op_type_t'(1) << I_LDS, TYPE_STS = op_type_t'(1) << I_STS;
  localparam op_type_t TYPE_RJMP = op_type_t'(1) << I_RJMP, TYPE_BREQ = op_type_t'(1) << I_BREQ;
  localparam op_type_t TYPE_BRVC = op_type_t'(1) << I_BRVC, TYPE_BRBS = op_type_t'(1) << I_BRBS;
  localparam op_type_t TYPE_IN = op_type_t'(1) << I_IN, TYPE_OUT = op_type_t'(1) << I_OUT;
  localparam op_type_t TYPE_UNKNOWN = op_type_t'(1) << I_UNKNOWN;
  localparam logic [5:0] ENC_ADD_PREFIX = 6'b0000_11, ENC_ADC_PREFIX = 6'b0001_11;
  localparam logic [5:0] ENC_SUB_PREFIX = 6'b0001_10, ENC_CP_PREFIX = 6'b0001_01;
  localparam logic [5:0] ENC_AND_PREFIX = 6'b0010_00, ENC_EOR_PREFIX = 6'b0010_01;
  localparam logic [5:0] ENC_OR_PREFIX = 6'b0010_10, ENC_MOV_PREFIX = 6'b0010_11;
  localparam logic [6:0] ENC_NEG_PREFIX = 7'b1001_010, ENC_LDY_PREFIX = 7'b1000_000;
  localparam logic [3:0] ENC_LDI_PREFIX = 4'b1110, ENC_RJMP_PREFIX = 4'b1100;
  localparam logic [4:0] ENC_LDS_PREFIX = 5'b1010_0, ENC_STS_PREFIX = 5'b1010_1;
  localparam logic [4:0] ENC_IN_PREFIX = 5'b1011_0, ENC_OUT_PREFIX = 5'b1011_1;
  localparam logic [5:0] ENC_BR_PREFIX = 6'b1111_00, ENC_BRVC_PREFIX = 6'b1111_01;
  localparam int RD_LSB = 4, RR_HI_POS = 9, BR_K_LSB = 3, IO_HI_LSB = 9;
endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request stream (in_*) and word stream (out_*); master drives requests, slave is the encoder
interface instr_encoder_if import instr_encoder_pkg::*; #(parameter int ADDR_WIDTH = 10, parameter int R_ADDR_WIDTH = 5);
  logic in_valid, in_ready, out_valid, out_ready;
  op_type_t in_type;
  logic [R_ADDR_WIDTH-1:0] in_rd, in_rr;
  logic [11:0] in_imd;
  logic [2:0] in_bit;
  logic [15:0] out_instr;
  logic [ADDR_WIDTH-1:0] out_addr;
  modport master(output in_valid, in_type, in_rd, in_rr, in_imd, in_bit, out_ready,
                 input in_ready, out_valid, out_instr, out_addr);
  modport slave(input in_valid, in_type, in_rd, in_rr, in_imd, in_bit, out_ready,
                output in_ready, out_valid, out_instr, out_addr);
endinterface

// File: rtl/instr_encoder_pack.sv
// instr_pack: combinational fields (typ, rd, rr, imd, bit_sel) -> {word, illegal}; range checks only under ENC_STRICT_CHECK_EN
module instr_pack import instr_encoder_pkg::*; #(parameter int R_ADDR_WIDTH = 5) (
  input  op_type_t                typ,
  input  logic [R_ADDR_WIDTH-1:0] rd,
  input  logic [R_ADDR_WIDTH-1:0] rr,
  input  logic [11:0]             imd,
  input  logic [2:0]              bit_sel,
  output logic [15:0]             word,
  output logic                    illegal
);
  logic [4:0] d, r;
  logic [5:0] alu_pre;
  logic one_hot;
  assign d = rd[4:0];
  assign r = rr[4:0];
  assign one_hot = typ != '0 && (typ & (typ - op_type_t'(1))) == '0;
  assign alu_pre = typ[I_ADD] ? ENC_ADD_PREFIX : typ[I_ADC] ? ENC_ADC_PREFIX :
                   typ[I_SUB] ? ENC_SUB_PREFIX : typ[I_CP] ? ENC_CP_PREFIX :
                   typ[I_AND] ? ENC_AND_PREFIX : typ[I_EOR] ? ENC_EOR_PREFIX :
                   typ[I_OR] ? ENC_OR_PREFIX : ENC_MOV_PREFIX;
  always_comb begin
    word = '0;
    if (!one_hot) word = '0;
    else if (|typ[I_MOV:I_ADD]) word = {alu_pre, r[4], d, r[3:0]};
    else if (typ[I_NEG]) word = {ENC_NEG_PREFIX, d, 4'b0001};
    else if (typ[I_LD_Y]) word = {ENC_LDY_PREFIX, d, 4'b1000};
    else if (typ[I_LDI]) word = {ENC_LDI_PREFIX, imd[7:4], d[3:0], imd[3:0]};
    else if (typ[I_LDS] || typ[I_STS])
      word = {typ[I_STS] ? ENC_STS_PREFIX : ENC_LDS_PREFIX, imd[5:4], imd[6], typ[I_STS] ? r[3:0] : d[3:0], imd[3:0]};
    else if (typ[I_RJMP]) word = {ENC_RJMP_PREFIX, imd};
    else if (typ[I_BREQ]) word = {ENC_BR_PREFIX, imd[6:0], 3'b001};
    else if (typ[I_BRVC]) word = {ENC_BRVC_PREFIX, imd[6:0], 3'b011};
    else if (typ[I_BRBS]) word = {ENC_BR_PREFIX, imd[6:0], bit_sel};
    else if (typ[I_IN]) word = {ENC_IN_PREFIX, imd[5:4], d, imd[3:0]};
    else if (typ[I_OUT]) word = {ENC_OUT_PREFIX, imd[5:4], r, imd[3:0]};
  end
`ifdef ENC_STRICT_CHECK_EN
  // branch offsets must sign-extend from 7 bits, so imd[11:6] is all ones or all zeros
  assign illegal = !one_hot || typ[I_UNKNOWN]
    || ((typ[I_LDI] || typ[I_LDS]) && rd < R_ADDR_WIDTH'(16))
    || (typ[I_STS] && rr < R_ADDR_WIDTH'(16))
    || (typ[I_LDI] && imd[11:8] != 4'h0)
    || ((typ[I_LDS] || typ[I_STS]) && (imd[7] == imd[6] || imd[11:8] != 4'h0))
    || ((typ[I_BREQ] || typ[I_BRVC] || typ[I_BRBS]) && !(&imd[11:6] || ~|imd[11:6]))
    || ((typ[I_IN] || typ[I_OUT]) && imd[11:6] != 6'h0);
`else
  assign illegal = 1'b0;
`endif
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: AVR word encoder with 2-entry output FIFO, write-address counter and reject counting; ports clk, reset, bus (instr_encoder_if.slave), addr_load/addr_base, err_pulse/err_cnt; strict checks under ENC_STRICT_CHECK_EN
module instr_encoder import instr_encoder_pkg::*; #(
  parameter int ADDR_WIDTH   = 10,
  parameter int R_ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_encoder_if.slave        bus,
  input  logic                  addr_load,
  input  logic [ADDR_WIDTH-1:0] addr_base,
  output logic                  err_pulse,
  output logic [7:0]            err_cnt
);
  typedef struct packed {
    logic [15:0]           instr;
    logic [ADDR_WIDTH-1:0] addr;
  } ent_t;
  ent_t s0, s1;
  logic [1:0] cnt;
  logic [ADDR_WIDTH-1:0] ctr, cur;
  logic [15:0] word;
  logic illegal, acc, push, pop;
  instr_pack #(.R_ADDR_WIDTH(R_ADDR_WIDTH)) u_pack (
    .typ(bus.in_type), .rd(bus.in_rd), .rr(bus.in_rr), .imd(bus.in_imd),
    .bit_sel(bus.in_bit), .word(word), .illegal(illegal)
  );
  assign bus.in_ready = cnt != 2'd2;
  assign bus.out_valid = cnt != 2'd0;
  assign bus.out_instr = s0.instr;
  assign bus.out_addr = s0.addr;
  assign acc = bus.in_valid && bus.in_ready;
  assign push = acc && !illegal;
  assign pop = bus.out_valid && bus.out_ready;
  assign cur = addr_load ? addr_base : ctr;
  // s0 is always the head; a push lands in the first free slot after any pop has shifted s1 down
  always_ff @(posedge clk) begin
    if (reset) begin
      s0 <= '0;
      s1 <= '0;
      cnt <= '0;
      ctr <= '0;
      err_pulse <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (pop) s0 <= s1;
      if (push && cnt == {1'b0, pop}) s0 <= {word, cur};
      else if (push) s1 <= {word, cur};
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
      if (push || addr_load) ctr <= cur + ADDR_WIDTH'(push);
      err_pulse <= acc && illegal;
      if (acc && illegal && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
endmodule
